rp_dmem_bridge: RTL and testbench
=================================

// Module: rp_dmem_bridge
// PURPOSE
//  Parametrised data-side bridge between cpu_top's dmem port and three targets: internal memory_system, external
//  memory port, and an on-chip MMIO register file (LEDs, status, cycle counter, scratch). Proper req/ready
//  handshake on every path, external-bus timeout with sticky error. Sits in the Red Pitaya top, below cpu_top.
// PARAMETERS
//  ADDR_WIDTH   64                 address width, all ports
//  DATA_WIDTH   64                 data width, all ports (>=32)
//  NUM_LED      8                  LED register width (<=DATA_WIDTH)
//  EXT_BASE     64'h0001_0000      first external address; below = internal
//  MMIO_BASE    64'hFFFF_0000      first MMIO address; >= MMIO_BASE = MMIO (EXT_BASE < MMIO_BASE)
//  TIMEOUT_CYC  255                max cycles waiting for ext_ready_i before abort (>=1)
//  ERR_DATA     64'hDEAD_BEEF_DEAD_BEEF  read data returned on timeout (truncated to DATA_WIDTH)
// PORTS
//  clk          in   1           single clock
//  rst_n        in   1           synchronous, active-low reset
//  dmem_addr    in   ADDR_WIDTH  CPU request address
//  dmem_write_data in DATA_WIDTH CPU write data
//  dmem_read    in   1           CPU read request, held until dmem_ready
//  dmem_write   in   1           CPU write request, held until dmem_ready
//  dmem_read_data out DATA_WIDTH response data, valid when dmem_ready
//  dmem_ready   out  1           one-cycle completion pulse
//  int_addr/int_wdata out ADDR_WIDTH/DATA_WIDTH  internal memory request
//  int_read/int_write out 1      held until int_ready
//  int_rdata    in   DATA_WIDTH  internal read data; int_ready in 1: internal completion
//  ext_req_o    out  1           external request, held until ext_ready_i or timeout
//  ext_addr_o/ext_wdata_o out ADDR_WIDTH/DATA_WIDTH; ext_we_o out 1: 1=write
//  ext_rdata_i  in   DATA_WIDTH; ext_ready_i in 1: external completion
//  led_o        out  NUM_LED     LED register
//  err_o        out  1           OR of sticky STATUS bits
// BEHAVIOUR
//  Reset (sync, any state): FSM->IDLE; all outputs 0 next edge (requests, ready, led_o, err_o, data); regs/cycle cnt 0.
//  FSM: IDLE, INT_WAIT, EXT_WAIT, RESP. Addresses, wdata, we latched at accept; downstream outputs registered.
//  IDLE: if dmem_read|dmem_write, accept; decode: addr>=MMIO_BASE->MMIO, >=EXT_BASE->EXT, else INT.
//    read&write together: treated as write, STATUS[1] set.
//    MMIO: access done in accept cycle, ->RESP (dmem_ready at accept+1).
//    INT: ->INT_WAIT, int_read/int_write high from accept+1.  EXT: ->EXT_WAIT, ext_req_o high from accept+1, tmo cnt=0.
//  INT_WAIT: on int_ready latch int_rdata, drop int_*, ->RESP.
//  EXT_WAIT: on ext_ready_i latch ext_rdata_i, drop ext_req_o, ->RESP; else cnt++; cnt==TIMEOUT_CYC-1 w/o ready
//    -> abort: drop ext_req_o, data=ERR_DATA (reads), STATUS[0] set, ->RESP. ready on abort cycle wins (no error).
//  RESP: dmem_ready=1 one cycle with data (writes: data 0); ->IDLE. CPU drops request the cycle after ready.
//  Min latency: MMIO 1 cycle accept->ready; INT/EXT = 2 + downstream wait cycles.
//  MMIO map (offset from MMIO_BASE, 8-byte aligned, full-word access):
//    0x00 LED RW [NUM_LED-1:0]; 0x08 STATUS R, W1C bits[1:0]; 0x10 CYCLE RO free-running, wraps at 2^DATA_WIDTH;
//    0x18 SCRATCH RW. Unmapped offsets: read 0, write ignored, no error.
//  CYCLE increments every cycle out of reset, incl. while stalled. W1C and new error same cycle: set wins.
//  led_o = LED reg directly; err_o = |STATUS, registered.
// STRUCTURE
//  Package rp_bridge_pkg: state enum (IDLE/INT_WAIT/EXT_WAIT/RESP), region enum (INT/EXT/MMIO),
//    MMIO offset localparams, STATUS bit indices.
//  One sub-module rp_mmio_regs: LED/STATUS/CYCLE/SCRATCH regs, write strobe + read mux; FSM/decode in top.
// TESTING
//  1 Write 0xA5 to MMIO_BASE+0x00 -> dmem_ready accept+1, led_o=0xA5; read back returns 0xA5.
//  2 Read internal addr 0x100, int_ready after 3 cycles with 0x1234 -> int_read held 3 cycles, dmem_read_data=0x1234.
//  3 Read EXT_BASE+0x40, ext_ready_i never -> ext_req_o drops after TIMEOUT_CYC, data=ERR_DATA, err_o=1;
//    write 0x1 to STATUS -> err_o=0.
//  4 ext_ready_i exactly on the abort cycle -> real data returned, STATUS[0] stays 0.
//  5 dmem_read&dmem_write together to SCRATCH with 0x77 -> SCRATCH=0x77, STATUS[1]=1.
//  6 rst_n low while in EXT_WAIT -> next edge ext_req_o=0, led_o=0, FSM IDLE; CYCLE read twice increases.

Source files
------------

// File: rtl/rp_dmem_bridge_pkg.sv
// Shared types and constants for the data-side bridge: FSM states, target regions,
// MMIO register offsets and STATUS bit positions.
package rp_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INT_WAIT = 2'd1,
    ST_EXT_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RG_INT  = 2'd0,
    RG_EXT  = 2'd1,
    RG_MMIO = 2'd2
  } region_t;

  localparam logic [63:0] OFF_LED     = 64'h00;
  localparam logic [63:0] OFF_STATUS  = 64'h08;
  localparam logic [63:0] OFF_CYCLE   = 64'h10;
  localparam logic [63:0] OFF_SCRATCH = 64'h18;

  localparam int STAT_TMO = 0;
  localparam int STAT_RW  = 1;
  localparam int NUM_STAT = 2;

endpackage

// File: rtl/rp_dmem_bridge_if.sv
// CPU dmem port: request held by the CPU until the one-cycle ready pulse.
interface rp_dmem_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  ready;

  modport master (output addr, write_data, read, write, input read_data, ready);
  modport slave  (input addr, write_data, read, write, output read_data, ready);
endinterface

// File: rtl/rp_dmem_bridge_mmio_regs.sv
// On-chip register file: LED, sticky STATUS (W1C), free-running CYCLE, SCRATCH.
// Reads are combinational so the bridge can answer in the accept cycle.
module rp_mmio_regs
  import rp_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_LED    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  set_tmo,
  input  logic                  set_rw,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [NUM_LED-1:0]    led_o,
  output logic                  err_o
);
  logic [NUM_LED-1:0]    led_reg;
  logic [NUM_STAT-1:0]   status_reg, status_next, set_vec;
  logic [DATA_WIDTH-1:0] cycle_reg, scratch_reg;
  logic                  err_reg;
  logic                  w1c;

  assign w1c     = we && (offset == ADDR_WIDTH'(OFF_STATUS));
  assign set_vec = {set_rw, set_tmo};

  // A new error in the same cycle as a clearing write must survive.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAT; gi++) begin : g_stat
      assign status_next[gi] = set_vec[gi] | (status_reg[gi] & ~(w1c & wdata[gi]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_reg     <= '0;
      status_reg  <= '0;
      cycle_reg   <= '0;
      scratch_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      cycle_reg  <= cycle_reg + DATA_WIDTH'(1);
      status_reg <= status_next;
      err_reg    <= |status_next;
      if (we && offset == ADDR_WIDTH'(OFF_LED))     led_reg     <= wdata[NUM_LED-1:0];
      if (we && offset == ADDR_WIDTH'(OFF_SCRATCH)) scratch_reg <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (offset == ADDR_WIDTH'(OFF_LED))          rdata = DATA_WIDTH'(led_reg);
    else if (offset == ADDR_WIDTH'(OFF_STATUS))  rdata = DATA_WIDTH'(status_reg);
    else if (offset == ADDR_WIDTH'(OFF_CYCLE))   rdata = cycle_reg;
    else if (offset == ADDR_WIDTH'(OFF_SCRATCH)) rdata = scratch_reg;
  end

  assign led_o = led_reg;
  assign err_o = err_reg;
endmodule

// File: rtl/rp_dmem_bridge.sv
// Data-side bridge from the CPU dmem port to internal memory, the external bus
// (with timeout abort) and the MMIO register file.
module rp_dmem_bridge
  import rp_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    NUM_LED     = 8,
  parameter logic [ADDR_WIDTH-1:0] EXT_BASE    = ADDR_WIDTH'(64'h0001_0000),
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = ADDR_WIDTH'(64'hFFFF_0000),
  parameter int                    TIMEOUT_CYC = 255,
  parameter logic [63:0]           ERR_DATA    = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rp_dmem_bridge_if.slave       dmem,
  output logic [ADDR_WIDTH-1:0] int_addr,
  output logic [DATA_WIDTH-1:0] int_wdata,
  output logic                  int_read,
  output logic                  int_write,
  input  logic [DATA_WIDTH-1:0] int_rdata,
  input  logic                  int_ready,
  output logic                  ext_req_o,
  output logic [ADDR_WIDTH-1:0] ext_addr_o,
  output logic [DATA_WIDTH-1:0] ext_wdata_o,
  output logic                  ext_we_o,
  input  logic [DATA_WIDTH-1:0] ext_rdata_i,
  input  logic                  ext_ready_i,
  output logic [NUM_LED-1:0]    led_o,
  output logic                  err_o
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t                state_reg, state_next;
  region_t               region;
  logic                  accept, abort, mmio_we;
  logic [CW-1:0]         tmo_reg;
  logic [DATA_WIDTH-1:0] rdata_reg, mmio_rdata;
  logic                  ready_reg;

  always_comb begin
    region = RG_INT;
    if (dmem.addr >= MMIO_BASE)     region = RG_MMIO;
    else if (dmem.addr >= EXT_BASE) region = RG_EXT;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (dmem.read || dmem.write) begin
          accept = 1'b1;
          case (region)
            RG_MMIO: state_next = ST_RESP;
            RG_EXT:  state_next = ST_EXT_WAIT;
            default: state_next = ST_INT_WAIT;
          endcase
        end
      end
      ST_INT_WAIT: if (int_ready) state_next = ST_RESP;
      ST_EXT_WAIT: begin
        // A ready arriving on the last allowed cycle still completes normally.
        if (ext_ready_i) begin
          state_next = ST_RESP;
        end else if (tmo_reg == CW'(TIMEOUT_CYC - 1)) begin
          abort      = 1'b1;
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mmio_we = accept && (region == RG_MMIO) && dmem.write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ready_reg   <= 1'b0;
      rdata_reg   <= '0;
      tmo_reg     <= '0;
      int_addr    <= '0;
      int_wdata   <= '0;
      int_read    <= 1'b0;
      int_write   <= 1'b0;
      ext_req_o   <= 1'b0;
      ext_addr_o  <= '0;
      ext_wdata_o <= '0;
      ext_we_o    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == ST_RESP);
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            rdata_reg <= '0;
            case (region)
              RG_MMIO: if (!dmem.write) rdata_reg <= mmio_rdata;
              RG_EXT: begin
                ext_addr_o  <= dmem.addr;
                ext_wdata_o <= dmem.write_data;
                ext_we_o    <= dmem.write;
                ext_req_o   <= 1'b1;
                tmo_reg     <= '0;
              end
              default: begin
                int_addr  <= dmem.addr;
                int_wdata <= dmem.write_data;
                int_read  <= !dmem.write;
                int_write <= dmem.write;
              end
            endcase
          end
        end
        ST_INT_WAIT: begin
          if (int_ready) begin
            rdata_reg <= int_write ? '0 : int_rdata;
            int_read  <= 1'b0;
            int_write <= 1'b0;
          end
        end
        ST_EXT_WAIT: begin
          if (ext_ready_i) begin
            rdata_reg <= ext_we_o ? '0 : ext_rdata_i;
            ext_req_o <= 1'b0;
          end else if (abort) begin
            rdata_reg <= ext_we_o ? '0 : DATA_WIDTH'(ERR_DATA);
            ext_req_o <= 1'b0;
          end else begin
            tmo_reg <= tmo_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.ready     = ready_reg;
  assign dmem.read_data = rdata_reg;

  rp_mmio_regs #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_LED   (NUM_LED)
  ) u_mmio (
    .clk    (clk),
    .rst_n  (rst_n),
    .offset (dmem.addr - MMIO_BASE),
    .we     (mmio_we),
    .wdata  (dmem.write_data),
    .set_tmo(abort),
    .set_rw (accept && dmem.read && dmem.write),
    .rdata  (mmio_rdata),
    .led_o  (led_o),
    .err_o  (err_o)
  );
endmodule

// File: tb/tb_rp_dmem_bridge.sv
// Bench for rp_dmem_bridge: directed vector table, reset-in-flight sequence, then
// random transactions scored against a transaction-level model.
module tb_rp_dmem_bridge;
  localparam int          TMO   = 12;
  localparam logic [63:0] EXTB  = 64'h0001_0000;
  localparam logic [63:0] MMIOB = 64'hFFFF_0000;
  localparam logic [63:0] ERRD  = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rp_dmem_bridge_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dmem_bus ();

  logic [63:0] int_addr, int_wdata, int_rdata, ext_addr_o, ext_wdata_o, ext_rdata_i;
  logic        int_read, int_write, int_ready, ext_req_o, ext_we_o, ext_ready_i, err_o;
  logic [7:0]  led_o;

  rp_dmem_bridge #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .dmem(dmem_bus),
    .int_addr(int_addr), .int_wdata(int_wdata), .int_read(int_read), .int_write(int_write),
    .int_rdata(int_rdata), .int_ready(int_ready),
    .ext_req_o(ext_req_o), .ext_addr_o(ext_addr_o), .ext_wdata_o(ext_wdata_o), .ext_we_o(ext_we_o),
    .ext_rdata_i(ext_rdata_i), .ext_ready_i(ext_ready_i), .led_o(led_o), .err_o(err_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_init(input logic [63:0] a);
    return {a[31:0], ~a[31:0]};
  endfunction

  // Stand-in memories: ready after a configured number of request cycles (0 = never).
  logic [63:0] rmem [logic [63:0]];
  int int_lat_cfg = 1;
  int ext_lat_cfg = 1;

  initial begin
    int icnt = 0;
    int_ready = 1'b0; int_rdata = '0;
    forever begin
      @(posedge clk); #1;
      int_ready = 1'b0;
      if (int_read || int_write) begin
        icnt++;
        if (icnt == int_lat_cfg) begin
          int_ready = 1'b1;
          if (int_write) rmem[int_addr] = int_wdata;
          else int_rdata = rmem.exists(int_addr) ? rmem[int_addr] : mem_init(int_addr);
        end
      end else icnt = 0;
    end
  end

  initial begin
    int ecnt = 0;
    ext_ready_i = 1'b0; ext_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      ext_ready_i = 1'b0;
      if (ext_req_o) begin
        ecnt++;
        if (ecnt == ext_lat_cfg) begin
          ext_ready_i = 1'b1;
          if (ext_we_o) rmem[ext_addr_o] = ext_wdata_o;
          else ext_rdata_i = rmem.exists(ext_addr_o) ? rmem[ext_addr_o] : mem_init(ext_addr_o);
        end
      end else ecnt = 0;
    end
  end

  logic [63:0] cyc;
  always @(posedge clk) cyc <= !rst_n ? 64'd0 : cyc + 64'd1;

  // Transaction-level reference model.
  logic [7:0]  m_led;
  logic [1:0]  m_status;
  logic [63:0] m_scratch;
  logic [63:0] m_mem [logic [63:0]];

  task automatic model_reset();
    m_led = '0; m_status = '0; m_scratch = '0;
  endtask

  task automatic model(input logic [63:0] a, wd, input bit rd, wr, input int il, el,
                       output logic [63:0] exp_rd, output int exp_lat, exp_ihi, exp_ehi);
    logic [63:0] off;
    bit tmo;
    int n;
    exp_rd = '0; exp_ihi = 0; exp_ehi = 0;
    if (a >= MMIOB) begin
      off = a - MMIOB;
      exp_lat = 1;
      if (wr) begin
        if (off == 64'h00) m_led = wd[7:0];
        if (off == 64'h08) m_status = m_status & ~wd[1:0];
        if (off == 64'h18) m_scratch = wd;
      end else begin
        if (off == 64'h00) exp_rd = {56'd0, m_led};
        if (off == 64'h08) exp_rd = {62'd0, m_status};
        if (off == 64'h10) exp_rd = cyc;
        if (off == 64'h18) exp_rd = m_scratch;
      end
    end else if (a >= EXTB) begin
      tmo = (el == 0) || (el > TMO);
      n = tmo ? TMO : el;
      exp_lat = n + 1; exp_ehi = n;
      if (tmo) begin
        m_status[0] = 1'b1;
        if (!wr) exp_rd = ERRD;
      end else if (wr) m_mem[a] = wd;
      else exp_rd = m_mem.exists(a) ? m_mem[a] : mem_init(a);
    end else begin
      exp_lat = il + 1; exp_ihi = il;
      if (wr) m_mem[a] = wd;
      else exp_rd = m_mem.exists(a) ? m_mem[a] : mem_init(a);
    end
    if (rd && wr) m_status[1] = 1'b1;
  endtask

  task automatic do_txn(input logic [63:0] a, wd, input bit rd, wr,
                        output logic [63:0] rdat, output int lat, ihi, ehi,
                        output bit dsok, output logic [7:0] ledv, output logic errv);
    dmem_bus.addr = a; dmem_bus.write_data = wd; dmem_bus.read = rd; dmem_bus.write = wr;
    lat = 0; ihi = 0; ehi = 0; dsok = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      lat++;
      if (int_read || int_write) begin
        ihi++;
        if (int_addr != a || int_write != wr || (wr && int_wdata != wd)) dsok = 1'b0;
      end
      if (ext_req_o) begin
        ehi++;
        if (ext_addr_o != a || ext_we_o != wr || (wr && ext_wdata_o != wd)) dsok = 1'b0;
      end
      if (dmem_bus.ready) break;
    end
    rdat = dmem_bus.read_data; ledv = led_o; errv = err_o;
    @(posedge clk); #1;
    dmem_bus.read = 1'b0; dmem_bus.write = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr; logic [63:0] wdata; bit rd; bit wr; int il; int el;
    logic [63:0] exp_rd; int exp_lat; logic [7:0] exp_led; bit exp_err;
  } vec_t;
  vec_t tbl [20];

  initial begin
    logic [63:0] rdat, mrd, c1;
    int lat, ihi, ehi, mlat, mihi, mehi;
    bit dsok;
    logic [7:0] ledv;
    logic errv;

    tbl[0]  = '{64'hFFFF_0000, 64'hA5,    0, 1, 1, 1,  64'h0,    1, 8'hA5, 0};
    tbl[1]  = '{64'hFFFF_0000, 64'h0,     1, 0, 1, 1,  64'hA5,   1, 8'hA5, 0};
    tbl[2]  = '{64'h100,       64'h1234,  0, 1, 1, 1,  64'h0,    2, 8'hA5, 0};
    tbl[3]  = '{64'h100,       64'h0,     1, 0, 3, 1,  64'h1234, 4, 8'hA5, 0};
    tbl[4]  = '{64'h1_0040,    64'h0,     1, 0, 1, 0,  ERRD,    13, 8'hA5, 1};
    tbl[5]  = '{64'hFFFF_0008, 64'h1,     0, 1, 1, 1,  64'h0,    1, 8'hA5, 0};
    tbl[6]  = '{64'h1_0040,    64'h0,     1, 0, 1, TMO, mem_init(64'h1_0040), 13, 8'hA5, 0};
    tbl[7]  = '{64'hFFFF_0008, 64'h0,     1, 0, 1, 1,  64'h0,    1, 8'hA5, 0};
    tbl[8]  = '{64'hFFFF_0018, 64'h77,    1, 1, 1, 1,  64'h0,    1, 8'hA5, 1};
    tbl[9]  = '{64'hFFFF_0018, 64'h0,     1, 0, 1, 1,  64'h77,   1, 8'hA5, 1};
    tbl[10] = '{64'hFFFF_0008, 64'h0,     1, 0, 1, 1,  64'h2,    1, 8'hA5, 1};
    tbl[11] = '{64'hFFFF_0008, 64'h2,     0, 1, 1, 1,  64'h0,    1, 8'hA5, 0};
    tbl[12] = '{64'hFFFF_0028, 64'hFF,    0, 1, 1, 1,  64'h0,    1, 8'hA5, 0};
    tbl[13] = '{64'hFFFF_0020, 64'h0,     1, 0, 1, 1,  64'h0,    1, 8'hA5, 0};
    tbl[14] = '{64'h2_0000,    64'hCAFE,  0, 1, 1, 2,  64'h0,    3, 8'hA5, 0};
    tbl[15] = '{64'h2_0000,    64'h0,     1, 0, 1, 1,  64'hCAFE, 2, 8'hA5, 0};
    tbl[16] = '{64'hFFF8,      64'h0,     1, 0, 1, 1,  mem_init(64'hFFF8), 2, 8'hA5, 0};
    tbl[17] = '{64'hFFFE_FFF8, 64'h0,     1, 0, 1, 1,  mem_init(64'hFFFE_FFF8), 2, 8'hA5, 0};
    tbl[18] = '{64'hFFFF_0000, 64'h13C,   0, 1, 1, 1,  64'h0,    1, 8'h3C, 0};
    tbl[19] = '{64'hFFFF_0000, 64'h0,     1, 0, 1, 1,  64'h3C,   1, 8'h3C, 0};

    dmem_bus.addr = '0; dmem_bus.write_data = '0; dmem_bus.read = 1'b0; dmem_bus.write = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {dmem_bus.ready, int_read, int_write, ext_req_o, ext_we_o, err_o, led_o}, 64'h0);
    check("rst_data", dmem_bus.read_data | int_addr | ext_addr_o | int_wdata | ext_wdata_o, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      int_lat_cfg = tbl[i].il; ext_lat_cfg = tbl[i].el;
      model(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr, tbl[i].il, tbl[i].el, mrd, mlat, mihi, mehi);
      do_txn(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr, rdat, lat, ihi, ehi, dsok, ledv, errv);
      check("vec_rdata", rdat, tbl[i].exp_rd);
      check("vec_lat", lat, tbl[i].exp_lat);
      check("vec_led", ledv, tbl[i].exp_led);
      check("vec_err", errv, tbl[i].exp_err);
      check("vec_ihi", ihi, (tbl[i].addr < EXTB) ? tbl[i].exp_lat - 1 : 0);
      check("vec_ehi", ehi, (tbl[i].addr >= EXTB && tbl[i].addr < MMIOB) ? tbl[i].exp_lat - 1 : 0);
      check("vec_ds", dsok, 1);
      $display("vec %0d addr=%h rd=%0d wr=%0d data=%h lat=%0d", i, tbl[i].addr, tbl[i].rd, tbl[i].wr, rdat, lat);
    end

    // Reset while the external bus is stalled.
    ext_lat_cfg = 0;
    dmem_bus.addr = 64'h1_0040; dmem_bus.read = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_req", ext_req_o, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_ext_req", ext_req_o, 0);
    check("rst_led", led_o, 0);
    check("rst_ready", dmem_bus.ready, 0);
    dmem_bus.read = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model(MMIOB + 64'h10, 64'h0, 1, 0, 1, 1, mrd, mlat, mihi, mehi);
    do_txn(MMIOB + 64'h10, 64'h0, 1, 0, rdat, lat, ihi, ehi, dsok, ledv, errv);
    check("cycle1", rdat, mrd);
    c1 = rdat;
    repeat (4) @(posedge clk);
    #1;
    model(MMIOB + 64'h10, 64'h0, 1, 0, 1, 1, mrd, mlat, mihi, mehi);
    do_txn(MMIOB + 64'h10, 64'h0, 1, 0, rdat, lat, ihi, ehi, dsok, ledv, errv);
    check("cycle2", rdat, mrd);
    check("cycle_incr", rdat > c1, 1);
    $display("reset seq cycle reads %0d then %0d", c1, rdat);

    for (int k = 0; k < 150; k++) begin
      logic [63:0] a, wd;
      bit rd, wr;
      int sel, op, il, el, r;
      sel = $urandom_range(0, 2);
      op  = $urandom_range(0, 7);
      rd = (op < 4) || (op == 7);
      wr = (op >= 4);
      case (sel)
        0:       a = 64'($urandom_range(0, 31)) * 8;
        1:       a = EXTB + 64'($urandom_range(0, 31)) * 8;
        default: a = MMIOB + 64'($urandom_range(0, 5)) * 8;
      endcase
      wd = {$urandom, $urandom};
      il = $urandom_range(1, 4);
      r  = $urandom_range(0, 9);
      el = (r == 0) ? 0 : (r == 1) ? TMO : (r == 2) ? TMO + 1 : $urandom_range(1, 4);
      int_lat_cfg = il; ext_lat_cfg = el;
      model(a, wd, rd, wr, il, el, mrd, mlat, mihi, mehi);
      do_txn(a, wd, rd, wr, rdat, lat, ihi, ehi, dsok, ledv, errv);
      check("rnd_rdata", rdat, mrd);
      check("rnd_lat", lat, mlat);
      check("rnd_ihi", ihi, mihi);
      check("rnd_ehi", ehi, mehi);
      check("rnd_led", ledv, m_led);
      check("rnd_err", errv, |m_status);
      check("rnd_ds", dsok, 1);
      $display("rnd %0d addr=%h rd=%0d wr=%0d il=%0d el=%0d data=%h lat=%0d", k, a, rd, wr, il, el, rdat, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
